// File: rtl/seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// seven_seg_scanner
//   Time-multiplexed four-digit seven-segment driver. All four digit values are
//   snapshotted once per scan frame, decoded to hex/decimal glyphs, and shown
//   one digit per slot with a blanking gap at the start of each slot.
//
//   Optional build macro: SCAN_LZB_EN -- leading-zero blanking of digits 3..1.
//
// Parameters
//   REFRESH_DIV : clock cycles per digit slot (>= DEAD_CYC+2)
//   DEAD_CYC    : cycles at slot start with all anodes off (0 = none)
// Ports
//   clk             in   system clock, rising edge
//   reset           in   asynchronous active-low reset
//   enable          in   1 = scan advances, 0 = scan frozen
//   mode            in   1 = hex glyphs, 0 = decimal (10-15 shown as dash)
//   count0..count3  in   digit values, count0 is rightmost (an[0])
//   dp_mask         in   per-digit decimal point enable (live, not snapshotted)
//   an              out  anodes, active-low
//   seg             out  cathodes g..a, active-low (seg[0] = a)
//   dp              out  decimal point, active-low
//   digit_sel       out  current slot index
// -----------------------------------------------------------------------------
module seven_seg_scanner #(
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYC    = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       mode,
    input  logic [3:0] count0,
    input  logic [3:0] count1,
    input  logic [3:0] count2,
    input  logic [3:0] count3,
    input  logic [3:0] dp_mask,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] digit_sel
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DW = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;

    logic [PW-1:0]   presc, presc_n;
    logic [1:0]      idx, idx_n;
    logic [DW-1:0]   dead, dead_n;
    logic [3:0][3:0] snap, snap_n;
    logic            primed, primed_n;
    logic            tick, capture, blank, lit;
    logic [3:0]      an_n;
    logic [6:0]      seg_n;
    logic            dp_n;

    function automatic logic [6:0] glyph(input logic [3:0] v, input logic hex);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        if (!hex && v > 4'd9) g = 7'b0111111;
        return g;
    endfunction

    // Next-state: slot timing, dead-time countdown, frame snapshot.
    always_comb begin
        tick     = enable && (presc == PW'(REFRESH_DIV - 1));
        presc_n  = presc;
        idx_n    = idx;
        dead_n   = dead;
        if (tick) begin
            presc_n = '0;
            idx_n   = idx + 2'd1;
            dead_n  = DW'(DEAD_CYC);
        end else if (enable) begin
            presc_n = presc + PW'(1);
            if (dead != '0) dead_n = dead - DW'(1);
        end
        // Capture at frame wrap, or on the first enabled edge after reset so
        // the display never starts from stale zeros.
        capture  = (tick && idx == 2'd3) || (enable && !primed);
        snap_n   = capture ? {count3, count2, count1, count0} : snap;
        primed_n = primed | enable;
    end

`ifdef SCAN_LZB_EN
    // A digit is a leading zero when it and every higher digit are zero.
    always_comb begin
        blank = 1'b0;
        case (idx_n)
            2'd3: blank = (snap_n[3] == 4'd0);
            2'd2: blank = (snap_n[3] == 4'd0) && (snap_n[2] == 4'd0);
            2'd1: blank = (snap_n[3] == 4'd0) && (snap_n[2] == 4'd0) &&
                          (snap_n[1] == 4'd0);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    // Outputs are registered from next-state values so they change on the
    // same edge as the slot index. mode and dp_mask are applied live. The
    // display stays dark until the first snapshot has been taken.
    always_comb begin
        lit   = primed_n && (dead_n == '0) && !blank;
        an_n  = lit ? ~(4'b0001 << idx_n) : 4'hF;
        seg_n = (primed_n && !blank) ? glyph(snap_n[idx_n], mode) : 7'h7F;
        dp_n  = lit ? ~dp_mask[idx_n] : 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc  <= '0;
            idx    <= '0;
            dead   <= '0;
            snap   <= '0;
            primed <= 1'b0;
            an     <= 4'hF;
            seg    <= 7'h7F;
            dp     <= 1'b1;
        end else begin
            presc  <= presc_n;
            idx    <= idx_n;
            dead   <= dead_n;
            snap   <= snap_n;
            primed <= primed_n;
            an     <= an_n;
            seg    <= seg_n;
            dp     <= dp_n;
        end
    end

    assign digit_sel = idx;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scanner
//   Directed bench for seven_seg_scanner with REFRESH_DIV=4, DEAD_CYC=1.
//   Inputs are driven and outputs sampled on the falling clock edge.
//   Expected glyphs for blanked slots follow SCAN_LZB_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_seven_seg_scanner;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable, mode;
    logic [3:0] count0, count1, count2, count3, dp_mask;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] digit_sel;

    int nvec = 0;
    int nerr = 0;

`ifdef SCAN_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    seven_seg_scanner #(.REFRESH_DIV(4), .DEAD_CYC(1)) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode),
        .count0(count0), .count1(count1), .count2(count2), .count3(count3),
        .dp_mask(dp_mask), .an(an), .seg(seg), .dp(dp), .digit_sel(digit_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s @%0t: got %0h want %0h", tag, $time, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called just after a tick edge: one dead cycle, then the lit digit.
    // Returns positioned just after the next tick edge.
    task automatic slot(input logic [1:0] s, input logic [3:0] an_lit, input logic [6:0] sg);
        chk("sel_dead", digit_sel, s);
        chk("an_dead", an, 4'hF);
        chk("seg_dead", seg, sg);
        cyc(1);
        chk("sel_lit", digit_sel, s);
        chk("an_lit", an, an_lit);
        chk("seg_lit", seg, sg);
        cyc(3);
    endtask

    initial begin
        reset   = 1'b1;
        enable  = 1'b1;
        mode    = 1'b1;
        count0  = 4'd4; count1 = 4'd3; count2 = 4'd2; count3 = 4'd1;
        dp_mask = 4'b0000;
        #1 reset = 1'b0;
        cyc(1);
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_dp", dp, 1'b1);
        chk("rst_sel", digit_sel, 2'd0);
        cyc(1);
        chk("rst_hold_an", an, 4'hF);
        reset = 1'b1;

        // First frame: slot 0 lit straight away (dead counter is 0 after reset).
        cyc(1);
        chk("f0_an", an, 4'b1110);
        chk("f0_seg", seg, 7'b0011001);
        chk("f0_sel", digit_sel, 2'd0);
        chk("f0_dp", dp, 1'b1);
        cyc(3);
        slot(2'd1, 4'b1101, 7'b0110000);
        slot(2'd2, 4'b1011, 7'b0100100);
        slot(2'd3, 4'b0111, 7'b1111001);
        slot(2'd0, 4'b1110, 7'b0011001);

        // Snapshot isolation: count0 changes during slot 1.
        count0 = 4'd9;
        slot(2'd1, 4'b1101, 7'b0110000);
        slot(2'd2, 4'b1011, 7'b0100100);
        slot(2'd3, 4'b0111, 7'b1111001);
        slot(2'd0, 4'b1110, 7'b0010000);

        // Mode: count2 = C shown as dash in decimal mode.
        count2 = 4'hC;
        mode   = 1'b0;
        slot(2'd1, 4'b1101, 7'b0110000);
        slot(2'd2, 4'b1011, 7'b0100100);
        slot(2'd3, 4'b0111, 7'b1111001);
        slot(2'd0, 4'b1110, 7'b0010000);
        slot(2'd1, 4'b1101, 7'b0110000);
        chk("dash_dead", seg, 7'b0111111);
        cyc(1);
        chk("dash_an", an, 4'b1011);
        chk("dash_seg", seg, 7'b0111111);
        mode    = 1'b1;
        dp_mask = 4'b0100;
        cyc(1);
        chk("hexC_seg", seg, 7'b1000110);
        chk("dp_on", dp, 1'b0);

        // Enable freeze for 20 cycles in slot 2 (two slot cycles used so far).
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            chk("frz_sel", digit_sel, 2'd2);
            chk("frz_an", an, 4'b1011);
            chk("frz_dp", dp, 1'b0);
        end
        enable = 1'b1;
        cyc(1);
        chk("resume_sel", digit_sel, 2'd2);
        chk("resume_an", an, 4'b1011);
        cyc(1);
        chk("resume_tick_sel", digit_sel, 2'd3);
        chk("resume_tick_an", an, 4'hF);
        count0 = 4'd7; count1 = 4'd0; count2 = 4'd0; count3 = 4'd0;
        cyc(1);
        chk("s3_an", an, 4'b0111);
        chk("s3_seg", seg, 7'b1111001);
        chk("s3_dp", dp, 1'b1);
        cyc(3);

        // Leading zeros: 0,0,0,7.
        slot(2'd0, 4'b1110, 7'b1111000);
        slot(2'd1, LZB ? 4'hF : 4'b1101, LZB ? 7'h7F : 7'b1000000);
        slot(2'd2, LZB ? 4'hF : 4'b1011, LZB ? 7'h7F : 7'b1000000);
        count0 = 4'd0;
        slot(2'd3, LZB ? 4'hF : 4'b0111, LZB ? 7'h7F : 7'b1000000);
        slot(2'd0, 4'b1110, 7'b1000000);

        // Asynchronous reset during a lit slot.
        cyc(1);
        chk("pre_rst_an", an, LZB ? 4'hF : 4'b1101);
        #2 reset = 1'b0;
        #1;
        chk("arst_an", an, 4'hF);
        chk("arst_seg", seg, 7'h7F);
        chk("arst_sel", digit_sel, 2'd0);
        chk("arst_dp", dp, 1'b1);
        count0 = 4'd5; count1 = 4'd6; count2 = 4'd7; count3 = 4'd8;
        cyc(1);
        reset = 1'b1;
        cyc(1);
        chk("rearm_an", an, 4'b1110);
        chk("rearm_seg", seg, 7'b0010010);
        cyc(3);
        chk("rearm_s1_sel", digit_sel, 2'd1);
        chk("rearm_s1_seg", seg, 7'b0000010);
        cyc(1);
        chk("rearm_s1_an", an, 4'b1101);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
